// File: rtl/axis_framer.sv
// Frames an unframed AXI-Stream beat source: a frame closes on input tlast,
// on reaching MAX_FRAME_LEN beats, or after IDLE_TIMEOUT idle cycles.
module axis_framer #(
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_FRAME_LEN = 64,
  parameter int IDLE_TIMEOUT  = 1000,
  parameter int COUNT_WIDTH   = 16,
  localparam int KEEP_WIDTH   = (DATA_WIDTH + 7) / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  i_s_tdata,
  input  logic                   i_s_tvalid,
  input  logic                   i_s_tlast,
  output logic                   o_s_tready,
  output logic [DATA_WIDTH-1:0]  o_m_tdata,
  output logic                   o_m_tvalid,
  input  logic                   i_m_tready,
  output logic                   o_m_tlast,
  output logic [KEEP_WIDTH-1:0]  o_m_tkeep,
  output logic                   o_m_tid,
  output logic                   o_m_tdest,
  output logic                   o_m_tuser,
  output logic [COUNT_WIDTH-1:0] o_frame_count
);

  localparam int IDX_WIDTH  = (MAX_FRAME_LEN > 1) ? $clog2(MAX_FRAME_LEN) : 1;
  localparam int IDLE_WIDTH = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(MAX_FRAME_LEN - 1);
  localparam logic [IDLE_WIDTH-1:0] IDLE_MAX = IDLE_WIDTH'(IDLE_TIMEOUT);

  logic [DATA_WIDTH-1:0]  r_h_data;
  logic                   r_h_valid;
  logic                   r_h_last_in;
  logic [IDX_WIDTH-1:0]   r_h_idx;
  logic [IDLE_WIDTH-1:0]  r_idle_cnt;
  logic [DATA_WIDTH-1:0]  r_o_data;
  logic                   r_o_valid;
  logic                   r_o_last;
  logic                   r_o_user;
  logic [COUNT_WIDTH-1:0] r_frame_count;

  logic w_o_free, w_at_max, w_timed_out, w_closable;
  logic w_ready, w_accept, w_close, w_continue, w_move;

  always_comb begin
    w_o_free    = !r_o_valid || i_m_tready;
    w_at_max    = (r_h_idx == LAST_IDX);
    w_timed_out = (r_idle_cnt == IDLE_MAX);
    w_closable  = r_h_valid && (r_h_last_in || w_at_max || w_timed_out);
    w_ready     = !reset && (!r_h_valid || w_o_free);
    w_accept    = i_s_tvalid && w_ready;
    w_close     = w_closable && w_o_free;
    // A non-closing beat only leaves H when its successor arrives.
    w_continue  = r_h_valid && !w_closable && w_o_free && w_accept;
    w_move      = w_close || w_continue;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_h_data    <= '0;
      r_h_valid   <= 1'b0;
      r_h_last_in <= 1'b0;
      r_h_idx     <= '0;
    end else if (w_accept) begin
      r_h_data    <= i_s_tdata;
      r_h_last_in <= i_s_tlast;
      r_h_valid   <= 1'b1;
      r_h_idx     <= (!r_h_valid || w_close) ? '0 : r_h_idx + 1'b1;
    end else if (w_move) begin
      r_h_valid   <= 1'b0;
    end
  end

  // Keeps counting while O is stalled so a timeout can fire once O frees up.
  always_ff @(posedge clk) begin
    if (reset || w_accept || w_move) begin
      r_idle_cnt <= '0;
    end else if (r_h_valid && !w_timed_out) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_o_data  <= '0;
      r_o_valid <= 1'b0;
      r_o_last  <= 1'b0;
      r_o_user  <= 1'b0;
    end else if (w_move) begin
      r_o_data  <= r_h_data;
      r_o_valid <= 1'b1;
      r_o_last  <= w_close;
      r_o_user  <= w_close && !r_h_last_in && !w_at_max;
    end else if (i_m_tready) begin
      r_o_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_count <= '0;
    end else if (r_o_valid && i_m_tready && r_o_last) begin
      r_frame_count <= r_frame_count + 1'b1;
    end
  end

  assign o_s_tready    = w_ready;
  assign o_m_tdata     = r_o_data;
  assign o_m_tvalid    = r_o_valid;
  assign o_m_tlast     = r_o_last;
  assign o_m_tuser     = r_o_user;
  assign o_m_tkeep     = '1;
  assign o_m_tid       = 1'b0;
  assign o_m_tdest     = 1'b0;
  assign o_frame_count = r_frame_count;

endmodule

// File: tb/tb_axis_framer.sv
// Directed bench for axis_framer: idle, max-length and tlast closes,
// backpressure, mid-frame reset and frame counter wrap.
module tb_axis_framer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sTdata = 8'h00;
   logic       sTvalid = 1'b0;
   logic       sTlast = 1'b0;
   logic       mTready = 1'b1;
   int         sel = 0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic       aReady, aValid, aLast, aUser, aId, aDest, aKeep;
   logic [7:0] aData;
   logic [15:0] aCount;
   logic       bReady, bValid, bLast, bUser, bId, bDest, bKeep;
   logic [7:0] bData;
   logic [15:0] bCount;
   logic       cReady, cValid, cLast, cUser, cId, cDest, cKeep;
   logic [7:0] cData;
   logic [3:0] cCount;

   logic       wReady, wValid, wLast, wUser, wId, wDest, wKeep;
   logic [7:0] wData;
   logic [15:0] wCount;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       u;
      int         c;
   } beat_t;
   beat_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   axis_framer u_def (
      .clk(clk), .reset(reset), .i_s_tdata(sTdata), .i_s_tvalid(sTvalid), .i_s_tlast(sTlast),
      .o_s_tready(aReady), .o_m_tdata(aData), .o_m_tvalid(aValid), .i_m_tready(mTready),
      .o_m_tlast(aLast), .o_m_tkeep(aKeep), .o_m_tid(aId), .o_m_tdest(aDest),
      .o_m_tuser(aUser), .o_frame_count(aCount));

   axis_framer #(.MAX_FRAME_LEN(4)) u_max4 (
      .clk(clk), .reset(reset), .i_s_tdata(sTdata), .i_s_tvalid(sTvalid), .i_s_tlast(sTlast),
      .o_s_tready(bReady), .o_m_tdata(bData), .o_m_tvalid(bValid), .i_m_tready(mTready),
      .o_m_tlast(bLast), .o_m_tkeep(bKeep), .o_m_tid(bId), .o_m_tdest(bDest),
      .o_m_tuser(bUser), .o_frame_count(bCount));

   axis_framer #(.MAX_FRAME_LEN(1), .COUNT_WIDTH(4)) u_wrap (
      .clk(clk), .reset(reset), .i_s_tdata(sTdata), .i_s_tvalid(sTvalid), .i_s_tlast(sTlast),
      .o_s_tready(cReady), .o_m_tdata(cData), .o_m_tvalid(cValid), .i_m_tready(mTready),
      .o_m_tlast(cLast), .o_m_tkeep(cKeep), .o_m_tid(cId), .o_m_tdest(cDest),
      .o_m_tuser(cUser), .o_frame_count(cCount));

   // All three instances see the same input; sel picks the one under test.
   always_comb begin
      {wReady, wValid, wLast, wUser, wId, wDest, wKeep} = {aReady, aValid, aLast, aUser, aId, aDest, aKeep};
      wData  = aData;
      wCount = aCount;
      if (sel == 1) begin
         {wReady, wValid, wLast, wUser, wId, wDest, wKeep} = {bReady, bValid, bLast, bUser, bId, bDest, bKeep};
         wData  = bData;
         wCount = bCount;
      end else if (sel == 2) begin
         {wReady, wValid, wLast, wUser, wId, wDest, wKeep} = {cReady, cValid, cLast, cUser, cId, cDest, cKeep};
         wData  = cData;
         wCount = {12'h000, cCount};
      end
   end

   // Records every output handshake with the cycle it happens in.
   always @(negedge clk) begin
      if (!reset && wValid && mTready) q.push_back('{wData, wLast, wUser, cyc});
   end

   // Compares an observed value against its expectation and tallies the result.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one beat on the sink and waits until it is accepted.
   task automatic applyStimulus(input logic [7:0] data, input logic last, output int accCyc);
      bit done = 0;
      sTdata  = data;
      sTlast  = last;
      sTvalid = 1'b1;
      accCyc  = -1;
      for (int i = 0; i < 2000 && !done; i++) begin
         @(negedge clk);
         if (wReady) begin
            accCyc = cyc;
            done   = 1;
         end
         @(posedge clk);
         #1;
      end
      checkOutput("accept_timeout", 32'(done), 32'd1);
   endtask

   // Waits until n output beats have been recorded or the budget runs out.
   task automatic waitBeats(input int n, input int budget);
      for (int i = 0; i < budget && q.size() < n; i++) tick(1);
      checkOutput("beat_wait_timeout", 32'(q.size() >= n), 32'd1);
   endtask

   task automatic doReset();
      sTvalid = 1'b0;
      sTlast  = 1'b0;
      reset   = 1'b1;
      tick(3);
      reset   = 1'b0;
      q.delete();
   endtask

   initial begin
      int acc;
      int acc33;
      logic [7:0] beats[6];
      logic flag;

      // Reset values
      sel = 0;
      mTready = 1'b1;
      tick(2);
      @(negedge clk);
      checkOutput("reset_sink_tready", 32'(wReady), 32'd0);
      checkOutput("reset_tvalid", 32'(wValid), 32'd0);
      checkOutput("reset_tdata", 32'(wData), 32'h00);
      checkOutput("reset_tlast", 32'(wLast), 32'd0);
      checkOutput("reset_tuser", 32'(wUser), 32'd0);
      checkOutput("reset_count", 32'(wCount), 32'd0);
      checkOutput("tkeep_ones", 32'(wKeep), 32'd1);
      checkOutput("tid_zero", 32'(wId), 32'd0);
      checkOutput("tdest_zero", 32'(wDest), 32'd0);
      doReset();

      // Idle close on defaults
      applyStimulus(8'h11, 1'b0, acc);
      applyStimulus(8'h22, 1'b0, acc);
      applyStimulus(8'h33, 1'b0, acc33);
      sTvalid = 1'b0;
      waitBeats(3, 1200);
      tick(2);
      checkOutput("idle_b0_data", 32'(q[0].d), 32'h11);
      checkOutput("idle_b0_last", 32'(q[0].l), 32'd0);
      checkOutput("idle_b1_data", 32'(q[1].d), 32'h22);
      checkOutput("idle_b1_last", 32'(q[1].l), 32'd0);
      checkOutput("idle_b2_data", 32'(q[2].d), 32'h33);
      checkOutput("idle_b2_last", 32'(q[2].l), 32'd1);
      checkOutput("idle_b2_user", 32'(q[2].u), 32'd1);
      checkOutput("idle_latency", 32'(q[2].c - acc33), 32'd1002);
      checkOutput("idle_count", 32'(wCount), 32'd1);

      // Max length of 4 with continuous stream of ten beats
      sel = 1;
      doReset();
      for (int i = 0; i < 10; i++) applyStimulus(8'(i), 1'b0, acc);
      sTvalid = 1'b0;
      waitBeats(10, 1200);
      tick(2);
      for (int i = 0; i < 10; i++) begin
         checkOutput("max_data", 32'(q[i].d), 32'(i));
         checkOutput("max_last", 32'(q[i].l), (i == 3 || i == 7 || i == 9) ? 32'd1 : 32'd0);
         checkOutput("max_user", 32'(q[i].u), (i == 9) ? 32'd1 : 32'd0);
      end
      checkOutput("max_count", 32'(wCount), 32'd3);

      // Input tlast closes, next beat opens a new frame
      sel = 0;
      doReset();
      applyStimulus(8'hA0, 1'b0, acc);
      applyStimulus(8'hA1, 1'b1, acc);
      applyStimulus(8'hB0, 1'b0, acc);
      sTvalid = 1'b0;
      waitBeats(3, 1200);
      tick(2);
      checkOutput("tlast_a0_last", 32'(q[0].l), 32'd0);
      checkOutput("tlast_a1_data", 32'(q[1].d), 32'hA1);
      checkOutput("tlast_a1_last", 32'(q[1].l), 32'd1);
      checkOutput("tlast_a1_user", 32'(q[1].u), 32'd0);
      checkOutput("tlast_b0_data", 32'(q[2].d), 32'hB0);
      checkOutput("tlast_b0_last", 32'(q[2].l), 32'd1);
      checkOutput("tlast_count", 32'(wCount), 32'd2);

      // Backpressure: two beats held, then a 20-cycle stall
      doReset();
      beats = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
      mTready = 1'b0;
      applyStimulus(beats[0], 1'b0, acc);
      applyStimulus(beats[1], 1'b0, acc);
      sTdata = beats[2];
      flag = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (wReady !== 1'b0 || wValid !== 1'b1 || wData !== 8'hC0 || wLast !== 1'b0) flag = 1'b0;
         @(posedge clk);
         #1;
      end
      checkOutput("bp_sink_tready_low", 32'(wReady), 32'd0);
      checkOutput("bp_stall_stable", 32'(flag), 32'd1);
      mTready = 1'b1;
      for (int i = 2; i < 6; i++) applyStimulus(beats[i], 1'b0, acc);
      sTvalid = 1'b0;
      waitBeats(6, 1200);
      for (int i = 0; i < 6; i++) begin
         checkOutput("bp_data", 32'(q[i].d), 32'(beats[i]));
         checkOutput("bp_last", 32'(q[i].l), (i == 5) ? 32'd1 : 32'd0);
      end

      // Reset in the middle of an open frame
      sel = 1;
      doReset();
      applyStimulus(8'hD0, 1'b0, acc);
      applyStimulus(8'hD1, 1'b0, acc);
      applyStimulus(8'hD2, 1'b0, acc);
      sTvalid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_sink_tready", 32'(wReady), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("rst_mid_tvalid", 32'(wValid), 32'd0);
      checkOutput("rst_mid_tdata", 32'(wData), 32'h00);
      checkOutput("rst_mid_tlast", 32'(wLast), 32'd0);
      checkOutput("rst_mid_tuser", 32'(wUser), 32'd0);
      checkOutput("rst_mid_count", 32'(wCount), 32'd0);
      tick(20);
      flag = 1'b0;
      foreach (q[i]) if (q[i].l) flag = 1'b1;
      checkOutput("rst_mid_no_tlast", 32'(flag), 32'd0);
      checkOutput("rst_mid_idle_tvalid", 32'(wValid), 32'd0);
      q.delete();
      for (int i = 0; i < 4; i++) applyStimulus(8'hE0 + 8'(i), 1'b0, acc);
      sTvalid = 1'b0;
      waitBeats(4, 50);
      tick(2);
      checkOutput("rst_next_e2_last", 32'(q[2].l), 32'd0);
      checkOutput("rst_next_e3_data", 32'(q[3].d), 32'hE3);
      checkOutput("rst_next_e3_last", 32'(q[3].l), 32'd1);
      checkOutput("rst_next_e3_user", 32'(q[3].u), 32'd0);
      checkOutput("rst_next_count", 32'(wCount), 32'd1);

      // Frame counter wrap with single-beat frames
      sel = 2;
      doReset();
      for (int i = 0; i < 17; i++) applyStimulus(8'h40 + 8'(i), 1'b0, acc);
      sTvalid = 1'b0;
      waitBeats(17, 100);
      tick(2);
      flag = 1'b1;
      foreach (q[i]) if (q[i].l !== 1'b1) flag = 1'b0;
      checkOutput("wrap_all_tlast", 32'(flag), 32'd1);
      checkOutput("wrap_count", 32'(wCount), 32'd1);

      $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
